// File: rtl/spongent_hash_ctrl.sv
// spongent_hash_ctrl: master-side sequencer for a spongent core.
// Takes RATE-bit message blocks over valid/ready and absorbs them into the core.
// It then absorbs the mandatory 10* padding block and squeezes NBLK blocks into
// the digest. The digest is presented with a valid/ack handshake.
module spongent_hash_ctrl #(
    parameter int RATE      = 8,
    parameter int HASH_SIZE = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RATE-1:0]      msg_data,
    input  logic                 msg_valid,
    input  logic                 msg_last,
    output logic                 msg_ready,
    output logic [HASH_SIZE-1:0] digest,
    output logic                 digest_valid,
    input  logic                 digest_ack,
    output logic                 ctrl_busy,
    output logic                 core_reset,
    output logic                 core_start_continue,
    output logic                 core_msg_data_available,
    output logic [RATE-1:0]      core_data_in,
    input  logic                 core_busy,
    input  logic [RATE-1:0]      core_data_out
);

    localparam int NBLK = HASH_SIZE / RATE;
    localparam int CW   = $clog2(NBLK + 1);

    localparam logic [CW-1:0]   CNT_LAST  = CW'(NBLK - 1);
    localparam logic [RATE-1:0] PAD_BLOCK = RATE'(1) << (RATE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CRST   = 3'd1;
    localparam logic [2:0] S_ABSORB = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_ARM    = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_SQCAP  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic MODE_ABSORB  = 1'b0;
    localparam logic MODE_SQUEEZE = 1'b1;

    logic [2:0]           state;
    logic                 mode;
    logic                 last_r;
    logic                 pad_done;
    logic [CW-1:0]        cnt;
    logic [HASH_SIZE-1:0] digest_shift;

    // The first squeezed block ends up in the MSBs after NBLK left shifts.
    generate
        if (NBLK == 1) begin : g_single_blk
            assign digest_shift = core_data_out;
        end else begin : g_multi_blk
            assign digest_shift = {digest[HASH_SIZE-RATE-1:0], core_data_out};
        end
    endgenerate

    assign msg_ready           = (state == S_ABSORB);
    assign digest_valid        = (state == S_DONE);
    assign ctrl_busy           = (state != S_IDLE);
    assign core_start_continue = (state == S_ISSUE);
    // The core is held in reset by the controller's reset as well as by CRST.
    assign core_reset          = reset | (state == S_CRST);

    // Controller FSM plus the datapath registers it owns.
    // NOTE: all state is updated with non-blocking assignments so that every
    // register samples values from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= S_IDLE;
            mode                    <= MODE_ABSORB;
            last_r                  <= 1'b0;
            pad_done                <= 1'b0;
            cnt                     <= '0;
            digest                  <= '0;
            core_data_in            <= '0;
            core_msg_data_available <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The pending block is left on the bus; ABSORB takes it.
                    if (msg_valid) state <= S_CRST;
                end
                S_CRST: begin
                    digest   <= '0;
                    pad_done <= 1'b0;
                    cnt      <= '0;
                    mode     <= MODE_ABSORB;
                    state    <= S_ABSORB;
                end
                S_ABSORB: begin
                    if (msg_valid) begin
                        core_data_in            <= msg_data;
                        last_r                  <= msg_last;
                        core_msg_data_available <= 1'b1;
                        state                   <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_ARM;
                // The core may take one cycle to raise busy, so busy is not looked at here.
                S_ARM:   state <= S_WAIT;
                S_WAIT: begin
                    if (!core_busy) begin
                        if (mode == MODE_SQUEEZE) begin
                            state <= S_SQCAP;
                        end else if (!last_r) begin
                            state <= S_ABSORB;
                        end else if (!pad_done) begin
                            // Whole-block input means padding is always its own block.
                            core_data_in            <= PAD_BLOCK;
                            core_msg_data_available <= 1'b1;
                            pad_done                <= 1'b1;
                            state                   <= S_ISSUE;
                        end else begin
                            mode  <= MODE_SQUEEZE;
                            state <= S_SQCAP;
                        end
                    end
                end
                S_SQCAP: begin
                    digest <= digest_shift;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                    end else begin
                        core_msg_data_available <= 1'b0;
                        state                   <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    if (digest_ack) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
